instr_type_decode: RTL
======================

Name: instr_type_decode

Overview:
- Pipelined front end of the decode stage. Accepts raw 32-bit RV32I instruction words with their PC over a valid/ready handshake.
- Classifies the opcode into the one-hot type flags that the control decoder consumes (R, I, L, S, B, J, Jr, lui, aui).
- Extracts the register and function fields and builds the sign-extended immediate.
- Presents the registered result downstream through a 2-entry skid buffer, with flush support and an illegal-instruction counter.

Parameters:
- XLEN, 32, instruction, PC and immediate width.
- CNT_W, 16, width of the saturating illegal-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous reset, active-high.
- in_valid  input  1  instruction word present.
- in_ready  output  1  stage can accept a word this cycle.
- instr  input  32  raw instruction.
- pc_in  input  XLEN  PC of instr.
- flush  input  1  discard all buffered and incoming words.
- out_valid  output  1  decoded entry present.
- out_ready  input  1  downstream accepts the entry.
- R, I, L, S, B, J, Jr, lui, aui  output  1 each  one-hot type flags.
- illegal  output  1  unrecognised encoding.
- rd, rs1, rs2  output  5 each  register fields.
- funct3  output  3  instr[14:12].
- funct7  output  7  instr[31:25].
- imm  output  XLEN  sign-extended immediate.
- pc_out  output  XLEN  PC of the presented entry.
- illegal_count  output  CNT_W  count of accepted illegal words.

Behaviour:
- Reset (asynchronous, rst=1):
  - out_valid=0 and skid entry empty.
  - All flags, illegal, fields, imm and pc_out = 0.
  - illegal_count=0; in_ready=1 on the first cycle after release.
- Accept and latency:
  - A word is accepted when in_valid && in_ready && !flush.
  - Latency 1: the decoded entry appears on the outputs the cycle after acceptance.
- Opcode classification on instr[6:0]:
  - 0110011 → R
  - 0010011 → I
  - 0000011 → L
  - 0100011 → S
  - 1100011 → B
  - 1101111 → J
  - 1100111 → Jr
  - 0110111 → lui
  - 0010111 → aui
  - Any other opcode, or instr[1:0]≠11 → all flags 0, illegal=1, imm=0.
  - Exactly one of the ten outputs (nine flags plus illegal) is 1 while out_valid=1.
- Immediate:
  - I/L/Jr: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - lui/aui: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R: 0.
- Fields:
  - rd, rs1, rs2, funct3 and funct7 are always taken from their fixed bit positions, regardless of type.
- Skid buffer: output register plus one skid register.
  - in_ready = !skid_valid, driven from a register (no combinational path from out_ready).
  - Accept while the output register is empty, or being drained (out_ready=1) → load the output register.
  - Accept while out_valid && !out_ready → load the skid register.
  - Output drained while the skid register is full → skid moves to the output register; in_ready=1 next cycle.
  - Accept and drain in the same cycle with the skid empty → new entry replaces the output register; out_valid stays 1.
  - Ordering is strictly FIFO. The output entry is held stable while out_valid && !out_ready.
- Flush:
  - Synchronous. At the next edge out_valid=0, the skid register is emptied and in_ready=1.
  - The word presented in the flush cycle is dropped and not counted.
  - flush has priority over acceptance and over drain.
- illegal_count:
  - +1 on each accepted word that decodes as illegal.
  - Saturates at 2^CNT_W−1.
  - Cleared only by rst.
- Reset mid-operation: all buffered entries are lost immediately; no partial entry is emitted.

Decomposition:
- Shared package rv_decode_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_L, OP_S, OP_B, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - a packed decoded-entry struct (flags, illegal, fields, imm, pc);
  - the imm_gen function.
- One combinational sub-module, instr_classify, maps instr to the packed entry. The top level holds the skid buffer, flush logic and counter.

Test Plan:
- addi x1,x2,5 (0x00510093), pc 0x100 → next cycle: I=1, rd=1, rs1=2, funct3=0, imm=0x00000005, pc_out=0x100.
- lui x5,0x12345 (0x123452B7) → lui=1, rd=5, imm=0x12345000. sw x2,-4(x1) (0xFE20AE23) → S=1, rs1=1, rs2=2, imm=0xFFFFFFFC.
- beq x0,x0,-8 (0xFE000CE3) → B=1, imm=0xFFFFFFF8. jal x1,+2048 (0x001000EF) → J=1, imm=0x00000800.
- Sequence 0x00000000, 0xFFFFFFFF, addi → illegal=1 with all flags 0 for the first two, illegal_count=2, addi decoded normally.
- out_ready=0, feed A, B, C back-to-back:
  - A sits on the outputs, B goes to skid, in_ready=0, C is held.
  - Raise out_ready → A, B, C emitted in order on consecutive cycles with no loss or duplication.
- With A on the outputs and B in skid, assert flush for 1 cycle with C on the input:
  - next cycle out_valid=0, in_ready=1, C not emitted and not counted.
  - Then rst asserted mid-stream → all outputs 0 immediately.

Source files
------------

// File: rtl/rv_decode_pkg.sv
// Shared RV32I decode definitions: opcodes, the decoded-entry record and
// the immediate generator used by the classifier.
package rv_decode_pkg;

  localparam int DEC_XLEN = 32;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_L     = 7'b0000011;
  localparam logic [6:0] OP_S     = 7'b0100011;
  localparam logic [6:0] OP_B     = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef struct packed {
    logic                is_r;
    logic                is_i;
    logic                is_l;
    logic                is_s;
    logic                is_b;
    logic                is_j;
    logic                is_jr;
    logic                is_lui;
    logic                is_aui;
    logic                illegal;
    logic [4:0]          rd;
    logic [4:0]          rs1;
    logic [4:0]          rs2;
    logic [2:0]          funct3;
    logic [6:0]          funct7;
    logic [DEC_XLEN-1:0] imm;
    logic [DEC_XLEN-1:0] pc;
  } decoded_t;

  // R-type and every unrecognised opcode yield a zero immediate.
  function automatic logic [DEC_XLEN-1:0] imm_gen(input logic [31:0] instr);
    logic [DEC_XLEN-1:0] imm;
    imm = '0;
    case (instr[6:0])
      OP_I, OP_L, OP_JALR: imm = {{20{instr[31]}}, instr[31:20]};
      OP_S:                imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      OP_B:                imm = {{19{instr[31]}}, instr[31], instr[7],
                                  instr[30:25], instr[11:8], 1'b0};
      OP_LUI, OP_AUIPC:    imm = {instr[31:12], 12'b0};
      OP_JAL:              imm = {{11{instr[31]}}, instr[31], instr[19:12],
                                  instr[20], instr[30:21], 1'b0};
      default:             imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/instr_classify.sv
// Combinational RV32I classifier: raw word + PC -> packed decoded entry.
module instr_classify
  import rv_decode_pkg::*;
(
  input  logic [31:0]          instr,
  input  logic [DEC_XLEN-1:0]  pc,
  output decoded_t             entry
);

  always_comb begin
    entry        = '0;
    entry.rd     = instr[11:7];
    entry.rs1    = instr[19:15];
    entry.rs2    = instr[24:20];
    entry.funct3 = instr[14:12];
    entry.funct7 = instr[31:25];
    entry.imm    = imm_gen(instr);
    entry.pc     = pc;
    // All legal opcodes end in 2'b11, so the default also catches instr[1:0]!=11.
    case (instr[6:0])
      OP_R:     entry.is_r   = 1'b1;
      OP_I:     entry.is_i   = 1'b1;
      OP_L:     entry.is_l   = 1'b1;
      OP_S:     entry.is_s   = 1'b1;
      OP_B:     entry.is_b   = 1'b1;
      OP_JAL:   entry.is_j   = 1'b1;
      OP_JALR:  entry.is_jr  = 1'b1;
      OP_LUI:   entry.is_lui = 1'b1;
      OP_AUIPC: entry.is_aui = 1'b1;
      default:  entry.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/instr_type_decode.sv
// Decode front end: classifier feeding a 2-entry skid buffer, with flush
// and a saturating count of accepted illegal words.
module instr_type_decode
  import rv_decode_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      instr,
  input  logic [XLEN-1:0]  pc_in,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             R,
  output logic             I,
  output logic             L,
  output logic             S,
  output logic             B,
  output logic             J,
  output logic             Jr,
  output logic             lui,
  output logic             aui,
  output logic             illegal,
  output logic [4:0]       rd,
  output logic [4:0]       rs1,
  output logic [4:0]       rs2,
  output logic [2:0]       funct3,
  output logic [6:0]       funct7,
  output logic [XLEN-1:0]  imm,
  output logic [XLEN-1:0]  pc_out,
  output logic [CNT_W-1:0] illegal_count
);

  decoded_t         new_entry;
  decoded_t         out_q, out_d;
  decoded_t         skid_q, skid_d;
  logic             out_valid_q, out_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept;

  instr_classify u_classify (
    .instr (instr),
    .pc    (pc_in),
    .entry (new_entry)
  );

  // in_ready comes straight from a flop so out_ready never reaches it combinationally.
  assign in_ready = !skid_valid_q;
  assign accept   = in_valid && in_ready && !flush;

  always_comb begin
    out_d        = out_q;
    skid_d       = skid_q;
    out_valid_d  = out_valid_q;
    skid_valid_d = skid_valid_q;
    cnt_d        = cnt_q;
    if (flush) begin
      out_valid_d  = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!out_valid_q || out_ready) begin
      // Output slot frees up: the skid entry is older, so it goes first.
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_d       = new_entry;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = new_entry;
      skid_valid_d = 1'b1;
    end
    if (accept && new_entry.illegal && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q        <= '0;
      skid_q       <= '0;
      out_valid_q  <= 1'b0;
      skid_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      out_q        <= out_d;
      skid_q       <= skid_d;
      out_valid_q  <= out_valid_d;
      skid_valid_q <= skid_valid_d;
      cnt_q        <= cnt_d;
    end
  end

  assign out_valid     = out_valid_q;
  assign R             = out_q.is_r;
  assign I             = out_q.is_i;
  assign L             = out_q.is_l;
  assign S             = out_q.is_s;
  assign B             = out_q.is_b;
  assign J             = out_q.is_j;
  assign Jr            = out_q.is_jr;
  assign lui           = out_q.is_lui;
  assign aui           = out_q.is_aui;
  assign illegal       = out_q.illegal;
  assign rd            = out_q.rd;
  assign rs1           = out_q.rs1;
  assign rs2           = out_q.rs2;
  assign funct3        = out_q.funct3;
  assign funct7        = out_q.funct7;
  assign imm           = out_q.imm;
  assign pc_out        = out_q.pc;
  assign illegal_count = cnt_q;

endmodule
